grid_bram_read_arbiter: RTL
===========================

Name: grid_bram_read_arbiter

Overview:
Shares one read-only grid BRAM port among NUM_REQ independent read requesters, e.g. the per-batch/per-channel grid streamers of the memory control unit.
Grants one request per cycle in round-robin order and drives the BRAM enable/address. Tracks outstanding reads in a tag FIFO. Returns each read word to its originating requester with a one-hot valid.
Supports both fixed-latency BRAMs and BRAM controllers that supply a read-valid.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR, 10, BRAM address width
WIDTH, 16, BRAM data width
RD_LATENCY, 2, cycles from bram_en to bram_rddata valid; used only when BRAM_VALID_SIG=0
BRAM_VALID_SIG, 1, 1 = response marked by bram_rdvalid; 0 = response assumed RD_LATENCY cycles after bram_en
MAX_OUTSTANDING, 4, tag FIFO depth and maximum in-flight reads (power of 2, >= RD_LATENCY+1)

Ports:
bram_clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
req_addr  in  NUM_REQ*ADDR  per-requester address, slice i = [i*ADDR +: ADDR]
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR  BRAM read address
bram_rddata  in  WIDTH  BRAM read data
bram_rdvalid  in  1  read-data valid; ignored when BRAM_VALID_SIG=0
rsp_data  out  WIDTH  returned word, shared by all requesters
rsp_valid  out  NUM_REQ  one-hot: rsp_data belongs to requester i
outstanding  out  clog2(MAX_OUTSTANDING)+1  in-flight read count
busy  out  1  outstanding != 0
err_unexpected  out  1  sticky: response with empty tag FIFO

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - bram_en=0, bram_addr=0, rsp_valid=0, rsp_data=0, outstanding=0, err_unexpected=0.
  - RR pointer = 0; tag FIFO empty; latency shift pipe cleared.
- Grant:
  - req_ready is combinational from req_valid, the RR pointer and the full flag.
  - At most one bit is set per cycle, and only for a requester with req_valid=1.
  - Search starts at the pointer index and wraps modulo NUM_REQ.
  - After a handshake with requester g, pointer <= (g+1) mod NUM_REQ. With no handshake the pointer holds.
- Full: outstanding == MAX_OUTSTANDING -> req_ready=0 for all. A response in the same cycle does not unblock the grant; the grant resumes next cycle.
- Issue: a handshake in cycle t registers bram_en=1 and bram_addr=req_addr[g] in t+1, and pushes tag g into the FIFO in t. With no handshake, bram_en=0 and bram_addr holds.
- Response detect:
  - BRAM_VALID_SIG=1: bram_rdvalid.
  - BRAM_VALID_SIG=0: a 1-bit shift pipe of depth RD_LATENCY fed by bram_en; its output is the detect.
- Response output:
  - On detect at cycle r: pop tag k, rsp_data <= bram_rddata, rsp_valid <= one-hot(k) at r+1; otherwise rsp_valid <= 0.
  - No backpressure exists; requesters must sink rsp_valid.
  - Total latency in fixed mode: handshake t -> rsp_valid at t+RD_LATENCY+2.
- Ordering: responses return strictly in issue order (FIFO).
- outstanding:
  - Increments on handshake and decrements on detect; simultaneous events leave it unchanged.
  - Width covers MAX_OUTSTANDING exactly; it never wraps.
- Error:
  - Detect with an empty FIFO sets err_unexpected, which stays set until reset.
  - The FIFO is not popped, rsp_valid stays 0, and the grant logic continues.
- Reset mid-operation drops all in-flight reads; late bram_rdvalid after reset sets err_unexpected (BRAM_VALID_SIG=1).

Decomposition:
- Shared package kan_mem_pkg: clog2 function, tag width localparam TAG_W = clog2(NUM_REQ), and the OUTSTANDING_W width rule.
- Sub-module rr_arbiter (NUM_REQ): req vector and advance strobe in, one-hot grant and encoded index out; holds the pointer register.
- The tag FIFO is inline (circular buffer, ptr width clog2(MAX_OUTSTANDING)+1).

Test Plan:
- Single request: req_valid=0001, addr 0x05, fixed latency 2 -> bram_en at t+1 with addr 0x05; rsp_valid=0001 at t+4 with data mem[5].
- Contention: req_valid=1111 held, addrs 0x10..0x13 -> grants 0,1,2,3,0 on consecutive cycles; responses return in the same order with matching data.
- Fairness: requester 2 granted, then req_valid=0101 -> next grant is requester 0 (wrap), then 2; pointer updates only on handshake.
- Full: BRAM_VALID_SIG=1, MAX_OUTSTANDING=4, rdvalid held low -> 4 grants, then req_ready=0000 and outstanding=4. Pulse rdvalid once -> rsp_valid to the first tag, and a new grant one cycle later.
- Unexpected: rdvalid pulse with outstanding=0 -> err_unexpected=1 and stays set; rsp_valid remains 0; subsequent reads complete normally.
- Reset mid-flight: 3 outstanding, assert rst_n=0 asynchronously -> all outputs 0 immediately; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/kan_mem_pkg.sv
// Shared sizing helpers for the grid memory control blocks.
// Widths that depend on module parameters are exposed as functions so each
// instance can size its own tags and counters consistently.
package kan_mem_pkg;

    // Default requester count for the grid streamers.
    localparam int DEF_NUM_REQ = 4;

    // Default in-flight read depth.
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Tag width needed to name one requester (never narrower than 1 bit).
    function automatic int tag_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

    // Counter width that holds 0..max_out inclusive, so it never wraps.
    function automatic int outstanding_width(input int max_out);
        return clog2(max_out) + 1;
    endfunction

    // Tag width for the default requester count.
    localparam int TAG_W = tag_width(DEF_NUM_REQ);

    // Outstanding counter width for the default depth.
    localparam int OUTSTANDING_W = outstanding_width(DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index.
// The search starts at the pointer and wraps; the pointer moves past the
// granted requester only when the caller reports a completed handshake.
module rr_arbiter
    import kan_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = tag_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // First requesting index at or after the pointer, modulo NUM_REQ.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(off);
            if (w_sum >= NUM_REQ_EXT) begin
                w_sum = w_sum - NUM_REQ_EXT;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

    // Pointer moves to the slot after the winner on a handshake, else holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == LAST_IDX) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/grid_bram_read_arbiter.sv
// Shares one read-only grid BRAM port among NUM_REQ requesters.
// One round-robin grant per cycle drives a registered BRAM enable/address;
// the requester tag is queued in a small FIFO and used to steer each
// returning word back with a one-hot valid, strictly in issue order.
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot at most and may only rise
// for a requester that is already asserting req_valid. Responses have no
// backpressure: rsp_valid[i] is a single-cycle pulse that must be consumed.
module grid_bram_read_arbiter
    import kan_mem_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR            = 10,
    parameter int WIDTH           = 16,
    parameter int RD_LATENCY      = 2,
    parameter int BRAM_VALID_SIG  = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                        bram_clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic [NUM_REQ*ADDR-1:0]                     req_addr,
    output logic                                        bram_en,
    output logic [ADDR-1:0]                             bram_addr,
    input  logic [WIDTH-1:0]                            bram_rddata,
    input  logic                                        bram_rdvalid,
    output logic [WIDTH-1:0]                            rsp_data,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    output logic [outstanding_width(MAX_OUTSTANDING)-1:0] outstanding,
    output logic                                        busy,
    output logic                                        err_unexpected
);

    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int AW    = clog2(MAX_OUTSTANDING);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(MAX_OUTSTANDING);

    // Registered BRAM side and response side.
    logic               r_bram_en;
    logic [ADDR-1:0]    r_bram_addr;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_err;

    // Tag FIFO: circular buffer with one extra pointer bit to tell full from empty.
    logic [TAG_W-1:0]   r_tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;

    logic [PTR_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [TAG_W-1:0]   w_grant_idx;
    logic               w_hs;
    logic [ADDR-1:0]    w_sel_addr;
    logic               w_detect;
    logic               w_pop;
    logic               w_unexp;
    logic [TAG_W-1:0]   w_head_tag;
    logic [NUM_REQ-1:0] w_head_onehot;

    // In-flight count is the pointer distance; it is registered state only,
    // so a response in the full cycle cannot reopen the grant until next cycle.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_count == FULL_COUNT);

    // Requests are hidden from the arbiter while the FIFO is full.
    assign w_arb_req = req_valid & {NUM_REQ{~w_full}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (TAG_W)
    ) u_rr_arbiter (
        .i_clk       (bram_clk),
        .i_rst_n     (rst_n),
        .i_req       (w_arb_req),
        .i_advance   (w_hs),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Every grant lands on an asserted req_valid, so any grant is a handshake.
    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    // One-hot mux of the winning requester's address slice.
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR +: ADDR];
            end
        end
    end

    // Response detect: either the controller's read-valid or a delayed copy of bram_en.
    generate
        if (BRAM_VALID_SIG != 0) begin : g_valid_sig
            assign w_detect = bram_rdvalid;
        end else begin : g_fixed_lat
            logic [RD_LATENCY-1:0] r_lat_pipe;
            logic                  w_unused_rdvalid;

            assign w_unused_rdvalid = bram_rdvalid;

            if (RD_LATENCY == 1) begin : g_lat1
                // Single-stage delay of the issued enable.
                always_ff @(posedge bram_clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_lat_pipe <= '0;
                    end else begin
                        r_lat_pipe <= r_bram_en;
                    end
                end
            end else begin : g_latn
                // Shift the issued enable through RD_LATENCY stages.
                always_ff @(posedge bram_clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_lat_pipe <= '0;
                    end else begin
                        r_lat_pipe <= {r_lat_pipe[RD_LATENCY-2:0], r_bram_en};
                    end
                end
            end

            assign w_detect = r_lat_pipe[RD_LATENCY-1];
        end
    endgenerate

    // A detect with nothing in flight is an error and must not disturb the FIFO.
    assign w_pop   = w_detect & ~w_empty;
    assign w_unexp = w_detect & w_empty;

    assign w_head_tag    = r_tag_mem[r_rd_ptr[AW-1:0]];
    assign w_head_onehot = NUM_REQ'(1) << w_head_tag;

    // Issue stage: register the BRAM enable and hold the last address when idle.
    always_ff @(posedge bram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
        end else begin
            r_bram_en <= w_hs;
            if (w_hs) begin
                r_bram_addr <= w_sel_addr;
            end
        end
    end

    // Tag FIFO: push the winner's tag on handshake, pop the head on a valid detect.
    always_ff @(posedge bram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else begin
            if (w_hs) begin
                r_tag_mem[r_wr_ptr[AW-1:0]] <= w_grant_idx;
                r_wr_ptr                    <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Response stage: steer the read word to the head tag; error flag is sticky.
    always_ff @(posedge bram_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            if (w_pop) begin
                r_rsp_data <= bram_rddata;
            end
            if (w_unexp) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bram_en        = r_bram_en;
    assign bram_addr      = r_bram_addr;
    assign rsp_data       = r_rsp_data;
    assign rsp_valid      = r_rsp_valid;
    assign outstanding    = w_count;
    assign busy           = |w_count;
    assign err_unexpected = r_err;

endmodule
